// File: rtl/alu_control_mc_pkg.sv
// Shared encodings for the registered ALU control: operation codes, funct codes,
// alu_op classes, sequencer states and the combinational instruction decoder.
package alu_control_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2
  } state_e;

  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_OR    = 5'h02;
  localparam logic [4:0] OP_ADD   = 5'h03;
  localparam logic [4:0] OP_LUI   = 5'h04;
  localparam logic [4:0] OP_SLL   = 5'h05;
  localparam logic [4:0] OP_SRL   = 5'h06;
  localparam logic [4:0] OP_AND   = 5'h07;
  localparam logic [4:0] OP_NOR   = 5'h08;
  localparam logic [4:0] OP_DEF   = 5'h09;
  localparam logic [4:0] OP_JR    = 5'h0A;
  localparam logic [4:0] OP_MULT  = 5'h0B;
  localparam logic [4:0] OP_MULTU = 5'h0C;
  localparam logic [4:0] OP_DIV   = 5'h0D;
  localparam logic [4:0] OP_DIVU  = 5'h0E;
  localparam logic [4:0] OP_MFHI  = 5'h0F;
  localparam logic [4:0] OP_MFLO  = 5'h10;
  localparam logic [4:0] OP_SLT   = 5'h11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] AOP_LUI   = 3'b001;
  localparam logic [2:0] AOP_ORI   = 3'b010;
  localparam logic [2:0] AOP_ANDI  = 3'b011;
  localparam logic [2:0] AOP_ADDI  = 3'b100;
  localparam logic [2:0] AOP_MEM   = 3'b101;
  localparam logic [2:0] AOP_RTYPE = 3'b111;

  typedef struct packed {
    logic [4:0] op;
    logic       illegal;
    logic       mul;
    logic       div;
    logic       hilo;
    logic       sgn;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] aop, input logic [5:0] fn);
    dec_t d;
    d    = '0;
    d.op = OP_DEF;
    case (aop)
      AOP_ADDI: d.op = OP_ADD;
      AOP_LUI:  d.op = OP_LUI;
      AOP_ORI:  d.op = OP_OR;
      AOP_ANDI: d.op = OP_AND;
      AOP_MEM:  d.op = OP_DEF;
      AOP_RTYPE: begin
        case (fn)
          FN_ADD:   d.op = OP_ADD;
          FN_SUB:   d.op = OP_SUB;
          FN_OR:    d.op = OP_OR;
          FN_SLL:   d.op = OP_SLL;
          FN_SRL:   d.op = OP_SRL;
          FN_AND:   d.op = OP_AND;
          FN_NOR:   d.op = OP_NOR;
          FN_JR:    d.op = OP_JR;
          FN_SLT:   d.op = OP_SLT;
          FN_MULT:  begin d.op = OP_MULT;  d.mul = 1'b1; d.hilo = 1'b1; d.sgn = 1'b1; end
          FN_MULTU: begin d.op = OP_MULTU; d.mul = 1'b1; d.hilo = 1'b1; end
          FN_DIV:   begin d.op = OP_DIV;   d.div = 1'b1; d.hilo = 1'b1; d.sgn = 1'b1; end
          FN_DIVU:  begin d.op = OP_DIVU;  d.div = 1'b1; d.hilo = 1'b1; end
          FN_MFHI:  begin d.op = OP_MFHI;  d.hilo = 1'b1; end
          FN_MFLO:  begin d.op = OP_MFLO;  d.hilo = 1'b1; end
          default:  d.illegal = 1'b1;
        endcase
      end
      default: d.op = OP_DEF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_control_mc_latency_counter.sv
// Down-counter timing the mult/div latency; clear dominates load, load dominates decrement.
module alu_control_mc_latency_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         clear,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_control_mc.sv
// Registered ALU control with a HI/LO sequencer for multi-cycle MULT/DIV and the
// pipeline stall that keeps HI/LO consumers and new mult/div ops out while busy.
module alu_control_mc
  import alu_control_mc_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int FUNCT_W  = 6,
  parameter int OPER_W   = 5,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [FUNCT_W-1:0]  alu_function_i,
  input  logic                flush_i,
  output logic [OPER_W-1:0]   alu_operation_o,
  output logic                op_valid_o,
  output logic                mc_start_o,
  output logic                mc_signed_o,
  output logic                stall_o,
  output logic                hilo_we_o,
  output logic                illegal_o,
  output state_e              state_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // Handshake: an instruction is taken when valid_i=1 and it is neither stalled
  // nor flushed; the decoded result appears on the outputs one edge later.
  state_e          state;
  dec_t            dec;
  logic            accept;
  logic            cnt_load;
  logic            cnt_en;
  logic            cnt_zero;
  logic [CW-1:0]   cnt_val;

  assign dec      = decode(3'(alu_op_i), 6'(alu_function_i));
  assign stall_o  = valid_i & (state != ST_IDLE) & dec.hilo;
  assign accept   = valid_i & ~stall_o & ~flush_i;
  assign cnt_load = (state == ST_IDLE) & accept & (dec.mul | dec.div);
  assign cnt_val  = dec.mul ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
  assign cnt_en   = (state != ST_IDLE) & ~cnt_zero;
  assign state_o  = state;

  alu_control_mc_latency_counter #(.W(CW)) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .clear    (flush_i),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      alu_operation_o <= OPER_W'(OP_DEF);
      op_valid_o      <= 1'b0;
      mc_start_o      <= 1'b0;
      mc_signed_o     <= 1'b0;
      hilo_we_o       <= 1'b0;
      illegal_o       <= 1'b0;
    end else begin
      op_valid_o <= 1'b0;
      mc_start_o <= 1'b0;
      hilo_we_o  <= 1'b0;
      illegal_o  <= 1'b0;
      if (accept) begin
        alu_operation_o <= OPER_W'(dec.op);
        op_valid_o      <= 1'b1;
        illegal_o       <= dec.illegal;
      end
      // A flush abandons any in-flight mult/div, so its result never reaches HI/LO.
      if (flush_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cnt_load) begin
              mc_start_o  <= 1'b1;
              mc_signed_o <= dec.sgn;
              state       <= dec.mul ? ST_MUL_BUSY : ST_DIV_BUSY;
            end
          end
          ST_MUL_BUSY, ST_DIV_BUSY: begin
            if (cnt_zero) begin
              hilo_we_o <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
